// File: rtl/moore_ser_pkg.sv
// Shared types and constants for the Moore detector serial stimulus stage.
package moore_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_t;

  localparam logic IDLE_LEVEL = 1'b0;
  localparam int   DEF_WIDTH  = 8;
  localparam int   DEF_DIV_W  = 8;

  // Bit-index counter width for a word of the given width.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/moore_ser_stim_if.sv
// Valid/ready pattern-word handshake feeding the serial stimulus stage.
interface moore_ser_stim_if
  import moore_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/moore_ser_prescaler.sv
// Bit-period down-counter: load sets the count, tick when it reaches zero,
// then it wraps to the reload value while enabled.
module moore_ser_prescaler
  import moore_ser_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic [DIV_W-1:0] i_reload_val,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= o_tick ? i_reload_val : (r_cnt - DIV_W'(1));
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/moore_ser_stim.sv
// Serializes pattern words MSB-first onto a registered x1 line with a
// programmable bit period. Optional word looping under MOORE_SER_LOOP_EN.
module moore_ser_stim
  import moore_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic                clk,
  input  logic                rst_n,
  moore_ser_stim_if.slave     in_if,
  input  logic [DIV_W-1:0]    div,
`ifdef MOORE_SER_LOOP_EN
  input  logic                loop_stop,
`endif
  output logic                x1,
  output logic                bit_strobe,
  output logic                done,
  output logic                busy
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_hold;
  logic               r_hold_valid;
  logic [WIDTH-2:0]   r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DIV_W-1:0]   r_div_q;
  logic               r_x1;
  logic               r_bit_strobe;
  logic               r_done;
  logic               r_busy;
`ifdef MOORE_SER_LOOP_EN
  logic [WIDTH-1:0]   r_word;
`endif

  logic               w_tick;
  logic               w_accept;
  logic               w_word_end;
  logic               w_repeat;
  logic               w_load;
  logic [WIDTH-1:0]   w_load_word;

  assign in_if.in_ready = ~r_hold_valid;
  assign w_accept       = in_if.in_valid & ~r_hold_valid;

  moore_ser_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_en         (r_state == ST_SHIFT),
    .i_load_val   (div),
    .i_reload_val (r_div_q),
    .o_tick       (w_tick)
  );

  // Loads happen from IDLE or at a word end; a pending hold word beats repeat.
  always_comb begin
    w_word_end  = (r_state == ST_SHIFT) && w_tick && (r_bit_cnt == '0);
    w_repeat    = 1'b0;
`ifdef MOORE_SER_LOOP_EN
    w_repeat    = w_word_end && !r_hold_valid && !loop_stop;
`endif
    w_load      = (((r_state == ST_IDLE) || w_word_end) && r_hold_valid) || w_repeat;
    w_load_word = r_hold;
`ifdef MOORE_SER_LOOP_EN
    if (!r_hold_valid) w_load_word = r_word;
`endif
  end

  // The MSB goes straight to x1 at load, so the shifter only keeps the
  // remaining WIDTH-1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_q      <= '0;
      r_x1         <= IDLE_LEVEL;
      r_bit_strobe <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef MOORE_SER_LOOP_EN
      r_word       <= '0;
`endif
    end else begin
      r_bit_strobe <= 1'b0;
      r_done       <= w_word_end;

      if (w_accept) begin
        r_hold       <= in_if.in_data;
        r_hold_valid <= 1'b1;
      end

      if (w_load) begin
        r_shift      <= w_load_word[WIDTH-2:0];
        r_x1         <= w_load_word[WIDTH-1];
        r_bit_cnt    <= BIT_LAST;
        r_div_q      <= div;
        r_bit_strobe <= 1'b1;
        r_busy       <= 1'b1;
        r_state      <= ST_SHIFT;
        if (r_hold_valid) r_hold_valid <= 1'b0;
`ifdef MOORE_SER_LOOP_EN
        if (r_hold_valid) r_word <= r_hold;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_x1   <= IDLE_LEVEL;
            r_busy <= 1'b0;
          end
          ST_SHIFT: begin
            if (w_tick) begin
              if (r_bit_cnt != '0) begin
                r_x1         <= r_shift[WIDTH-2];
                r_shift      <= r_shift << 1;
                r_bit_cnt    <= r_bit_cnt - CNT_W'(1);
                r_bit_strobe <= 1'b1;
              end else begin
                r_x1    <= IDLE_LEVEL;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end
          default: begin
            r_x1    <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign x1         = r_x1;
  assign bit_strobe = r_bit_strobe;
  assign done       = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_moore_ser_stim.sv
// Directed bench for moore_ser_stim; covers MOORE_SER_LOOP_EN when defined.
module tb_moore_ser_stim;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] div;
  logic       x1;
  logic       bit_strobe;
  logic       done;
  logic       busy;
`ifdef MOORE_SER_LOOP_EN
  logic       loop_stop;
`endif

  int errs   = 0;
  int checks = 0;

  moore_ser_stim_if #(.WIDTH(8)) bus_if ();

  moore_ser_stim #(
    .WIDTH (8),
    .DIV_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus_if),
    .div        (div),
`ifdef MOORE_SER_LOOP_EN
    .loop_stop  (loop_stop),
`endif
    .x1         (x1),
    .bit_strobe (bit_strobe),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Status vector: {x1, bit_strobe, done, busy, in_ready}
  function automatic logic [31:0] st();
    return {27'd0, x1, bit_strobe, done, busy, bus_if.in_ready};
  endfunction

  function automatic logic [31:0] mk(input logic x, input logic s, input logic d,
                                     input logic b, input logic r);
    return {27'd0, x, s, d, b, r};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word from IDLE and checks every cycle of its serial output.
  task automatic run_word(input logic [7:0] w, input int unsigned d, input bit chg);
    div             = 8'(d);
    bus_if.in_data  = w;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    check_eq("word_accept", st(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned r = 0; r <= d; r++) begin
        step();
        check_eq("word_bit", st(), mk(w[7-i], r == 0, 1'b0, 1'b1, 1'b1));
        if (chg && i == 3 && r == 0) div = 8'd0;
      end
    end
    step();
    check_eq("word_done", st(), mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    step();
    check_eq("word_idle", st(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    logic [15:0] stream;
    logic [7:0]  lw;
    int          dones;

    rst_n           = 1'b0;
    div             = 8'd0;
    bus_if.in_data  = 8'd0;
    bus_if.in_valid = 1'b0;
`ifdef MOORE_SER_LOOP_EN
    loop_stop       = 1'b1;
`endif

    #2;
    check_eq("in_reset", st(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step();
    step();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      step();
      check_eq("idle_after_reset", st(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end

    run_word(8'b0110_1100, 0, 1'b0);
    run_word(8'hA5, 2, 1'b1);

    // Back-to-back words, div left at 0 by the previous word.
    bus_if.in_data  = 8'hF0;
    bus_if.in_valid = 1'b1;
    step();
    check_eq("b2b_accept1", st(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus_if.in_data = 8'h0F;
    stream = 16'hF00F;
    dones  = 0;
    for (int unsigned c = 1; c <= 18; c++) begin
      step();
      check_eq("b2b_stream", st(),
               mk((c <= 16) ? stream[16-c] : 1'b0, c <= 16, (c == 9) || (c == 17),
                  c <= 16, (c == 1) || (c >= 9)));
      if (done) dones++;
      if (c == 2) bus_if.in_valid = 1'b0;
    end
    check_eq("b2b_done_count", dones, 2);

    // Async reset mid-word with a second word waiting in hold.
    bus_if.in_data  = 8'hFF;
    bus_if.in_valid = 1'b1;
    step();
    step();
    bus_if.in_data = 8'hC3;
    step();
    bus_if.in_valid = 1'b0;
    step();
    step();
    check_eq("pre_reset_bit4", st(), mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", st(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    #2;
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 20; c++) begin
      step();
      check_eq("post_reset_idle", st(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end

`ifdef MOORE_SER_LOOP_EN
    lw              = 8'h81;
    div             = 8'd0;
    loop_stop       = 1'b0;
    bus_if.in_data  = lw;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    dones = 0;
    for (int unsigned c = 1; c <= 28; c++) begin
      step();
      check_eq("loop_stream", st(),
               mk((c <= 24) ? lw[7-((c-1)%8)] : 1'b0, c <= 24,
                  (c == 9) || (c == 17) || (c == 25), c <= 24, 1'b1));
      if (done) dones++;
      if (c == 20) loop_stop = 1'b1;
    end
    check_eq("loop_done_count", dones, 3);
`else
    lw = 8'h00;
    stream = {stream[7:0], lw};
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/moore_ser_stim.md
Name: moore_ser_stim

Overview:
- Upstream stimulus stage for the Moore sequence detector.
- Accepts parallel bit patterns over a valid/ready handshake and serializes them MSB-first onto a single registered x1 line.
- The bit period is programmable through a clock prescaler.
- A one-entry holding register allows back-to-back words with no idle gap, so the detector sees a continuous serial stream.

Parameters:
- WIDTH, 8: pattern word width in bits (>=2).
- DIV_W, 8: prescaler divisor width; bit period = div+1 clk cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  WIDTH  pattern word, MSB shifted first
- in_valid  input  1  in_data valid
- in_ready  output  1  holding register empty; transfer on in_valid && in_ready at posedge
- div  input  DIV_W  bit-period divisor, sampled at each word load
- x1  output  1  serial bit to detector, registered
- bit_strobe  output  1  1-clk pulse on the cycle a new bit first appears on x1
- done  output  1  1-clk pulse at the end of each word's last bit period
- busy  output  1  high while in SHIFT

Behaviour:
- Reset (async, any time, including mid-word):
  - state=IDLE; hold_valid=0; shift, bit_cnt, pre_cnt, div_q = 0.
  - x1=0, bit_strobe=0, done=0, busy=0; in_ready=1 after reset.
  - Any in-flight word is discarded.
- Handshake:
  - in_ready = ~hold_valid (combinational from register only; no in_valid-to-in_ready path).
  - On accept: hold <= in_data; hold_valid <= 1.
  - in_data/in_valid are ignored while in_ready=0.
- States: IDLE, SHIFT (2-bit encoding from package).
- IDLE:
  - x1 held 0 (idle level).
  - If hold_valid: load shift<=hold, hold_valid<=0, div_q<=div, pre_cnt<=div, bit_cnt<=WIDTH-1, x1<=hold[WIDTH-1], bit_strobe<=1, go to SHIFT.
  - Latency: word accepted at edge k appears on x1 from edge k+1, and in_ready returns high at edge k+1.
- SHIFT:
  - pre_cnt decrements each clk.
  - pre_cnt==0 and bit_cnt!=0: shift left, x1<=next bit, bit_cnt--, pre_cnt<=div_q, bit_strobe<=1.
  - pre_cnt==0 and bit_cnt==0 (word end): done<=1. Then:
    - if hold_valid: reload exactly as in IDLE (no gap, bit_strobe<=1), stay in SHIFT;
    - else: go to IDLE, x1<=0.
- div handling:
  - div=0 gives one bit per clk; the word occupies exactly WIDTH cycles.
  - div changes mid-word are ignored until the next load.
- Simultaneous events:
  - Accept and hold-to-shifter transfer cannot share an edge, because in_ready=0 whenever hold is full.
  - done and a reload share an edge.
- Output timing: all outputs except in_ready are registered; no glitch paths (the detector may sample x1 on any edge).

Optional Feature:
- Macro: MOORE_SER_LOOP_EN.
- Defined:
  - Adds input loop_stop (1 bit).
  - At word end with hold empty and loop_stop=0, the last word reloads and repeats (done and bit_strobe still pulse).
  - A pending hold word always takes precedence over repeating.
  - loop_stop=1 sampled at word end sends the block to IDLE.
- Undefined: no loop_stop port; word end with hold empty always goes to IDLE.

Decomposition:
- Package moore_ser_pkg:
  - state encodings ST_IDLE=2'b00, ST_SHIFT=2'b01;
  - IDLE_LEVEL=1'b0;
  - default WIDTH/DIV_W constants.
- Sub-module moore_ser_prescaler:
  - DIV_W down-counter with load, reload value and tick output (tick when count==0);
  - instantiated once.
- Shifter, holding register and FSM stay in the top module.

Test Plan:
- Reset, then idle 5 clks -> x1=0, in_ready=1, busy=0, bit_strobe=0, done=0 throughout.
- div=0, accept 8'b0110_1100 at edge k -> x1 = 0,1,1,0,1,1,0,0 on edges k+1..k+8; bit_strobe high 8 cycles; done pulse at edge k+9; x1=0 and busy=0 afterwards.
- div=2, accept 8'hA5 -> each bit held 3 clks, 24-cycle word, 8 bit_strobe pulses spaced 3 apart; change div to 0 mid-word -> no effect until the next word.
- div=0, send 8'hF0 then 8'h0F with in_valid held high -> second word accepted the cycle after the first load; x1 shows 16 contiguous bits with no gap; exactly 2 done pulses.
- Assert rst_n low at bit 4 of a word with a word pending in hold -> x1=0, busy=0, in_ready=1 immediately (async); after release, no residual bits emitted.
- MOORE_SER_LOOP_EN, div=0, word 8'h81, loop_stop=0 -> pattern repeats for 3 words (3 done pulses); raise loop_stop -> current word completes, then IDLE with x1=0.
